serial_adder: RTL and testbench

- Bit-serial N-bit adder, the sequential stage that consumes the half-adder sum/carry primitive.
- Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake, adds them LSB-first with one bit per clock through a registered carry, and presents the WIDTH-bit sum and carry-out over a valid/ready handshake.
- Trades latency for area; sits between an operand source and a result consumer in the datapath.

---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one sum bit per clock, LSB first.
// Operands are taken over a valid/ready handshake and the result is returned over another.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid/ready operand handshake; in_ready is high only in IDLE
//   a, b, cin      operands and carry-in, captured on accept
//   out_valid/ready result handshake; out_valid is high only in DONE
//   sum, cout      (a+b+cin) mod 2^WIDTH and the carry out of the MSB
//   busy           high while an operation is in RUN or DONE
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // cnt only has to reach WIDTH-1, so it never wraps before the exit compare.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             s_bit;
    logic             carry_nx;

    assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nx = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = carry_nx;
                // New bit enters at the MSB; the shift form also covers WIDTH=1.
                sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = carry_nx;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder, WIDTH=8 and WIDTH=1 builds.
// Expected sums are queued on accept and compared when out_valid appears.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    logic [8:0] sb8[$];
    logic [1:0] sb1[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input int stall);
        logic [8:0] exp;
        int lat;
        chk("ir_before", 32'(ir8), 1);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        or8 = (stall == 0);
        tick();
        sb8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        iv8 = 1'b0;
        chk("ir_run", 32'(ir8), 0);
        chk("busy_run", 32'(busy8), 1);
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 8);
        chk("sb_nonempty", 32'(sb8.size() != 0), 1);
        exp = (sb8.size() != 0) ? sb8.pop_front() : 9'h1FF;
        chk("result", 32'({cout8, sum8}), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            if (i == 0) begin
                a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b1;
            end
            tick();
            chk("stall_ov", 32'(ov8), 1);
            chk("stall_ir", 32'(ir8), 0);
            chk("stall_res", 32'({cout8, sum8}), 32'(exp));
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("rel_ov", 32'(ov8), 0);
        chk("rel_ir", 32'(ir8), 1);
        chk("rel_busy", 32'(busy8), 0);
        chk("rel_hold", 32'({cout8, sum8}), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        iv1 = 0; or1 = 1; a1 = 0; b1 = 0; cin1 = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ir", 32'(ir8), 1);
        chk("rst_ov", 32'(ov8), 0);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_sum", 32'(sum8), 0);
        chk("rst_cout", 32'(cout8), 0);
        chk("rst1_ir", 32'(ir1), 1);
        chk("rst1_ov", 32'(ov1), 0);

        op8(8'h3C, 8'h0F, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'hA5, 8'h5A, 1'b1, 0);
        op8(8'h80, 8'h80, 1'b0, 5);
        op8(8'h5F, 8'h73, 1'b1, 2);

        // Abort an operation part way through RUN.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ir", 32'(ir8), 1);
        chk("abort_sum", 32'(sum8), 0);
        chk("abort_busy", 32'(busy8), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov8) seen++;
            tick();
        end
        chk("abort_no_ov", 32'(seen), 0);
        or8 = 1'b0;
        op8(8'h01, 8'h01, 1'b0, 0);

        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            logic [1:0] exp1;
            v = 3'(k);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1'b1;
            tick();
            sb1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            iv1 = 1'b0;
            chk("w1_run_ov", 32'(ov1), 0);
            tick();
            chk("w1_ov", 32'(ov1), 1);
            exp1 = (sb1.size() != 0) ? sb1.pop_front() : 2'b11;
            chk("w1_res", 32'({cout1, sum1}), 32'(exp1));
            tick();
            chk("w1_ir", 32'(ir1), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
